// File: rtl/parity_ctrl_pkg.sv
// Shared state encoding and parity constants
// for the parity frame controller.
package parity_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/parity_checker.sv
// Combinational parity check of one word
// plus its accompanying parity bit.
module parity_checker
    import parity_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_TYPE = PARITY_EVEN
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  parity_in,
    output logic                  valid_out
);

    logic odd_sel;

    assign odd_sel   = (PARITY_TYPE == PARITY_ODD);
    assign valid_out = ((^data_in) ^ parity_in) == odd_sel;

endmodule

// File: rtl/parity_frame_controller.sv
// Sequences a fixed-length frame of parity-protected
// words, flags errors and reports frame completion.
module parity_frame_controller
    import parity_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_TYPE = PARITY_EVEN,
    parameter int LEN_WIDTH   = 16,
    parameter int ERR_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [LEN_WIDTH-1:0]  frame_len_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  parity_in,
    input  logic                  data_valid_in,
    output logic                  data_ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic                  parity_err_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [ERR_WIDTH-1:0]  err_count_out,
    output logic                  frame_ok_out
);

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic                  ok_q, ok_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  dval_q, dval_d;
    logic                  perr_q, perr_d;

    logic                  word_good;
    logic                  beat;
    logic                  word_bad;
    logic [ERR_WIDTH-1:0]  err_inc;

    parity_checker #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PARITY_TYPE (PARITY_TYPE)
    ) u_chk (
        .data_in   (data_in),
        .parity_in (parity_in),
        .valid_out (word_good)
    );

    assign beat     = data_valid_in && (state_q == ST_ACTIVE);
    assign word_bad = !word_good;
    // Saturate instead of wrapping so a long bad frame never reads as clean
    assign err_inc  = (err_q == '1) ? err_q : err_q + ERR_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ok_d    = ok_q;
        data_d  = data_q;
        dval_d  = 1'b0;
        perr_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    err_d = '0;
                    if (frame_len_in != '0) begin
                        len_d   = frame_len_in;
                        cnt_d   = '0;
                        ok_d    = 1'b0;
                        state_d = ST_ACTIVE;
                    end else begin
                        ok_d    = 1'b1;
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_ACTIVE: begin
                if (abort_in) begin
                    ok_d    = 1'b0;
                    state_d = ST_IDLE;
                end else if (beat) begin
                    data_d = data_in;
                    dval_d = 1'b1;
                    perr_d = word_bad;
                    cnt_d  = cnt_q + LEN_WIDTH'(1);
                    if (word_bad) begin
                        err_d = err_inc;
                    end
                    if (cnt_q == len_q - LEN_WIDTH'(1)) begin
                        ok_d    = (err_d == '0);
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ok_q    <= 1'b0;
            data_q  <= '0;
            dval_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
            data_q  <= data_d;
            dval_q  <= dval_d;
            perr_q  <= perr_d;
        end
    end

    assign data_ready_out = (state_q == ST_ACTIVE);
    assign busy_out       = (state_q != ST_IDLE);
    assign done_out       = (state_q == ST_REPORT);
    assign data_out       = data_q;
    assign data_valid_out = dval_q;
    assign parity_err_out = perr_q;
    assign err_count_out  = err_q;
    assign frame_ok_out   = ok_q;

endmodule

// File: tb/tb_parity_frame_controller.sv
// Randomized frame bench for parity_frame_controller with
// even, odd and narrow-counter instances on shared inputs.
module tb_parity_frame_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_in = 1'b0;
    logic        abort_in = 1'b0;
    logic [15:0] frame_len_in = '0;
    logic [7:0]  data_in = '0;
    logic        parity_in = 1'b0;
    logic        data_valid_in = 1'b0;

    logic [7:0]  dout0, dout1, dout2;
    logic        rdy0, rdy1, rdy2;
    logic        dv0, dv1, dv2;
    logic        pe0, pe1, pe2;
    logic        bz0, bz1, bz2;
    logic        dn0, dn1, dn2;
    logic [15:0] ec0, ec1;
    logic [1:0]  ec2;
    logic        ok0, ok1, ok2;

    int          inst;
    logic [7:0]  o_dout;
    logic        o_rdy, o_dv, o_pe, o_bz, o_dn, o_ok;
    logic [15:0] o_ec;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] wq[$];
    bit         pq[$];

    always #5 clk = ~clk;

    parity_frame_controller #(
        .DATA_WIDTH(8), .PARITY_TYPE(0),
        .LEN_WIDTH(16), .ERR_WIDTH(16)
    ) dut_even (
        .clk(clk), .rst(rst), .start_in(start_in),
        .abort_in(abort_in), .frame_len_in(frame_len_in),
        .data_in(data_in), .parity_in(parity_in),
        .data_valid_in(data_valid_in),
        .data_ready_out(rdy0), .data_out(dout0),
        .data_valid_out(dv0), .parity_err_out(pe0),
        .busy_out(bz0), .done_out(dn0),
        .err_count_out(ec0), .frame_ok_out(ok0)
    );

    parity_frame_controller #(
        .DATA_WIDTH(8), .PARITY_TYPE(1),
        .LEN_WIDTH(16), .ERR_WIDTH(16)
    ) dut_odd (
        .clk(clk), .rst(rst), .start_in(start_in),
        .abort_in(abort_in), .frame_len_in(frame_len_in),
        .data_in(data_in), .parity_in(parity_in),
        .data_valid_in(data_valid_in),
        .data_ready_out(rdy1), .data_out(dout1),
        .data_valid_out(dv1), .parity_err_out(pe1),
        .busy_out(bz1), .done_out(dn1),
        .err_count_out(ec1), .frame_ok_out(ok1)
    );

    parity_frame_controller #(
        .DATA_WIDTH(8), .PARITY_TYPE(0),
        .LEN_WIDTH(16), .ERR_WIDTH(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .start_in(start_in),
        .abort_in(abort_in), .frame_len_in(frame_len_in),
        .data_in(data_in), .parity_in(parity_in),
        .data_valid_in(data_valid_in),
        .data_ready_out(rdy2), .data_out(dout2),
        .data_valid_out(dv2), .parity_err_out(pe2),
        .busy_out(bz2), .done_out(dn2),
        .err_count_out(ec2), .frame_ok_out(ok2)
    );

    always_comb begin
        o_dout = dout0; o_rdy = rdy0; o_dv = dv0; o_pe = pe0;
        o_bz = bz0; o_dn = dn0; o_ec = ec0; o_ok = ok0;
        if (inst == 1) begin
            o_dout = dout1; o_rdy = rdy1; o_dv = dv1; o_pe = pe1;
            o_bz = bz1; o_dn = dn1; o_ec = ec1; o_ok = ok1;
        end else if (inst == 2) begin
            o_dout = dout2; o_rdy = rdy2; o_dv = dv2; o_pe = pe2;
            o_bz = bz2; o_dn = dn2; o_ec = {14'd0, ec2}; o_ok = ok2;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame on instance 'sel' and checks every cycle against
    // a frame-level model. Queued words (wq/pq) are used first, else random.
    // gap<0: random 0..2 idle cycles before each word, else fixed before words 1..
    // bad_mode: 0 random parity, 1 every word bad. abort_at<0: no abort.
    task automatic run_frame(input int sel, input int pt, input int emax,
                             input int len, input int gap, input int bad_mode,
                             input int abort_at, input string tag);
        int exp_err;
        int g;
        bit bad;
        bit last;
        logic [7:0] d;
        bit p;
        logic [4:0] obs, exp;
        inst = sel;
        exp_err = 0;
        start_in = 1'b1;
        frame_len_in = 16'(len);
        step();
        start_in = 1'b0;
        if (len == 0) begin
            obs = {o_dv, o_dn, o_rdy, o_bz, o_ok};
            exp = 5'b01011;
            n_chk++;
            if (obs !== exp || o_ec !== 16'd0) begin
                n_fail++;
                $display("FAIL %s len0 report: flags=%b ec=%0d want flags=%b ec=0",
                         tag, obs, o_ec, exp);
            end
            step();
            obs = {o_dv, o_dn, o_rdy, o_bz, o_ok};
            exp = 5'b00001;
            n_chk++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s len0 after: flags=%b want %b", tag, obs, exp);
            end
            return;
        end
        obs = {o_dv, o_dn, o_rdy, o_bz, o_ok};
        exp = 5'b00110;
        n_chk++;
        if (obs !== exp || o_ec !== 16'd0) begin
            n_fail++;
            $display("FAIL %s start: flags=%b ec=%0d want flags=%b ec=0",
                     tag, obs, o_ec, exp);
        end
        for (int k = 0; k < len; k++) begin
            if (gap < 0) g = $urandom_range(0, 2);
            else g = (k == 0) ? 0 : gap;
            for (int c = 0; c < g; c++) begin
                data_valid_in = 1'b0;
                data_in = 8'($urandom);
                start_in = 1'($urandom);
                frame_len_in = 16'd0;
                step();
                obs = {o_dv, o_dn, o_rdy, o_bz, 1'b0};
                exp = 5'b00110;
                n_chk++;
                if (obs !== exp || o_ec !== 16'(exp_err)) begin
                    n_fail++;
                    $display("FAIL %s gap k=%0d: flags=%b ec=%0d want flags=%b ec=%0d",
                             tag, k, obs, o_ec, exp, exp_err);
                end
            end
            if (wq.size() > 0) begin
                d = wq.pop_front();
                p = pq.pop_front();
            end else begin
                d = 8'($urandom);
                p = 1'($urandom);
                if (bad_mode == 1) p = (^d) ^ pt[0] ^ 1'b1;
            end
            bad = (((^d) ^ p) != pt[0]);
            last = (k == len - 1);
            data_in = d;
            parity_in = p;
            data_valid_in = 1'b1;
            start_in = 1'($urandom);
            abort_in = (k == abort_at);
            step();
            data_valid_in = 1'b0;
            start_in = 1'b0;
            if (k == abort_at) begin
                abort_in = 1'b0;
                obs = {o_dv, o_dn, o_rdy, o_bz, o_ok};
                exp = 5'b00000;
                n_chk++;
                if (obs !== exp || o_ec !== 16'(exp_err)) begin
                    n_fail++;
                    $display("FAIL %s abort: flags=%b ec=%0d want flags=%b ec=%0d",
                             tag, obs, o_ec, exp, exp_err);
                end
                return;
            end
            if (bad && exp_err < emax) exp_err++;
            obs = {o_dv, o_pe, o_dn, o_rdy, o_bz};
            exp = {1'b1, bad, last, !last, 1'b1};
            n_chk++;
            if (obs !== exp || o_dout !== d || o_ec !== 16'(exp_err)) begin
                n_fail++;
                $display("FAIL %s word k=%0d: flags=%b dout=%h ec=%0d want flags=%b dout=%h ec=%0d",
                         tag, k, obs, o_dout, o_ec, exp, d, exp_err);
            end
            if (last) begin
                n_chk++;
                if (o_ok !== (exp_err == 0)) begin
                    n_fail++;
                    $display("FAIL %s frame_ok: got %b want %b", tag, o_ok, exp_err == 0);
                end
            end
        end
        start_in = 1'b1;
        frame_len_in = 16'd3;
        step();
        start_in = 1'b0;
        step();
        obs = {o_dv, o_dn, o_rdy, o_bz, o_ok};
        exp = {4'b0000, exp_err == 0};
        n_chk++;
        if (obs !== exp || o_ec !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL %s idle hold: flags=%b ec=%0d want flags=%b ec=%0d",
                     tag, obs, o_ec, exp, exp_err);
        end
    endtask

    task automatic test_reset();
        inst = 0;
        rst = 1'b1;
        start_in = 1'b1;
        frame_len_in = 16'd2;
        repeat (2) step();
        n_chk++;
        if ({dv0, rdy0, bz0, dn0, ok0, pe0} !== 6'b0 || ec0 !== 16'd0 || dout0 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset outputs: dv/rdy/bz/dn/ok/pe=%b ec=%0d dout=%h want all 0",
                     {dv0, rdy0, bz0, dn0, ok0, pe0}, ec0, dout0);
        end
        start_in = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        n_chk++;
        if (rdy0 !== 1'b0 || bz0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset idle: rdy=%b busy=%b want 0 0", rdy0, bz0);
        end
    endtask

    task automatic test_even_b2b();
        wq = '{8'hFF, 8'h54};
        pq = '{1'b0, 1'b1};
        run_frame(0, 0, 65535, 2, 0, 0, -1, "even_b2b");
    endtask

    task automatic test_even_gap();
        wq = '{8'h54, 8'h01, 8'h03};
        pq = '{1'b0, 1'b1, 1'b1};
        run_frame(0, 0, 65535, 3, 2, 0, -1, "even_gap");
    endtask

    task automatic test_odd();
        wq = '{8'hFF};
        pq = '{1'b1};
        run_frame(1, 1, 65535, 1, 0, 0, -1, "odd_good");
        wq = '{8'hFF};
        pq = '{1'b0};
        run_frame(1, 1, 65535, 1, 0, 0, -1, "odd_bad");
    endtask

    task automatic test_len0();
        run_frame(0, 0, 65535, 0, 0, 0, -1, "len0");
    endtask

    task automatic test_abort();
        run_frame(0, 0, 65535, 4, -1, 0, 1, "abort");
        step();
        n_chk++;
        if (o_bz !== 1'b0 || o_dn !== 1'b0 || o_dv !== 1'b0) begin
            n_fail++;
            $display("FAIL abort settle: busy=%b done=%b dv=%b want 0 0 0", o_bz, o_dn, o_dv);
        end
    endtask

    task automatic test_saturate();
        run_frame(2, 0, 3, 5, 0, 1, -1, "saturate");
    endtask

    task automatic test_random();
        int s;
        for (int i = 0; i < 24; i++) begin
            s = $urandom_range(0, 2);
            run_frame(s, (s == 1) ? 1 : 0, (s == 2) ? 3 : 65535,
                      $urandom_range(1, 9), -1, 0, -1, "random");
        end
    endtask

    task automatic test_reset_mid();
        inst = 0;
        start_in = 1'b1;
        frame_len_in = 16'd4;
        step();
        start_in = 1'b0;
        data_in = 8'h54;
        parity_in = 1'b0;
        data_valid_in = 1'b1;
        step();
        data_valid_in = 1'b0;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({o_dv, o_rdy, o_bz, o_dn, o_pe} !== 5'b0 || o_ec !== 16'd0 || o_dout !== 8'd0) begin
            n_fail++;
            $display("FAIL reset mid-frame: flags=%b ec=%0d dout=%h want 0",
                     {o_dv, o_rdy, o_bz, o_dn, o_pe}, o_ec, o_dout);
        end
        step();
        rst = 1'b0;
    endtask

    initial begin
        inst = 0;
        test_reset();
        test_even_b2b();
        test_even_gap();
        test_odd();
        test_len0();
        test_abort();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
